// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned divider (radix-2 restoring, one quotient
// bit per cycle). Operands arrive on a valid/ready input handshake and the
// result is held on a valid/ready output until the consumer takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds its data stable while valid && !ready. in_ready
// is a pure decode of the state register, so it has no combinational
// dependency on in_valid.
module seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_q,       state_d;
    logic [DIVISOR_W-1:0]  divisor_q,     divisor_d;
    logic [DIVIDEND_W-1:0] dividend_sh_q, dividend_sh_d;
    logic [DIVISOR_W:0]    pr_q,          pr_d;
    logic [DIVIDEND_W-1:0] quo_sh_q,      quo_sh_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic [DIVIDEND_W-1:0] quotient_q,    quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q,   remainder_d;
    logic                  dbz_q,         dbz_d;
    logic                  out_valid_q,   out_valid_d;

    logic [DIVISOR_W:0]    pr_shift;
    logic [DIVISOR_W:0]    pr_next;
    logic                  quo_bit;
    logic [DIVIDEND_W-1:0] quo_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The stored partial remainder is always < divisor, so its top bit is zero;
    // it is still folded into the compare so the step stays arithmetically
    // exact for any value held in pr_q.
    always_comb begin
        pr_shift = {pr_q[DIVISOR_W-1:0], dividend_sh_q[DIVIDEND_W-1]};
        quo_bit  = pr_q[DIVISOR_W] | (pr_shift >= {1'b0, divisor_q});
        pr_next  = quo_bit ? (pr_shift - {1'b0, divisor_q}) : pr_shift;
        quo_next = {quo_sh_q[DIVIDEND_W-2:0], quo_bit};
    end

    // Next-state and datapath update for IDLE -> CALC -> DONE -> IDLE.
    always_comb begin
        state_d       = state_q;
        divisor_d     = divisor_q;
        dividend_sh_d = dividend_sh_q;
        pr_d          = pr_q;
        quo_sh_d      = quo_sh_q;
        cnt_d         = cnt_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        dbz_d         = dbz_q;
        out_valid_d   = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    divisor_d     = divisor;
                    dividend_sh_d = dividend;
                    pr_d          = '0;
                    quo_sh_d      = '0;
                    cnt_d         = CNT_W'(DIVIDEND_W - 1);
                    if (divisor != '0) begin
                        state_d = CALC;
                    end else begin
                        // Zero divisor skips the iteration entirely.
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend[DIVISOR_W-1:0];
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end
                end
            end
            CALC: begin
                pr_d          = pr_next;
                quo_sh_d      = quo_next;
                dividend_sh_d = {dividend_sh_q[DIVIDEND_W-2:0], 1'b0};
                cnt_d         = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = quo_next;
                    remainder_d = pr_next[DIVISOR_W-1:0];
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset has priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            divisor_q     <= '0;
            dividend_sh_q <= '0;
            pr_q          <= '0;
            quo_sh_q      <= '0;
            cnt_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            dbz_q         <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            divisor_q     <= divisor_d;
            dividend_sh_q <= dividend_sh_d;
            pr_q          <= pr_d;
            quo_sh_q      <= quo_sh_d;
            cnt_q         <= cnt_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            dbz_q         <= dbz_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
